// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: EX operand forwarding, load-use stalls, mul/div stall sequencing with timeout.
// Optional HAZARD_PERF_CNT_EN adds saturating stall/flush performance counters.
module hazard_ctrl #(
    parameter int unsigned REG_ADDR_W    = 5,
    parameter int unsigned FWD_W         = 2,
    parameter int unsigned MD_MAX_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs1_addr,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [REG_ADDR_W-1:0] ex_rs1_addr,
    input  logic [REG_ADDR_W-1:0] ex_rs2_addr,
    input  logic [REG_ADDR_W-1:0] ex_rd_addr,
    input  logic                  ex_reg_we,
    input  logic                  ex_mem_rd,
    input  logic                  ex_md_start,
    input  logic                  md_done,
    input  logic                  branch_taken_ex,
    input  logic [REG_ADDR_W-1:0] m_rd_addr,
    input  logic                  m_reg_we,
    input  logic [REG_ADDR_W-1:0] wb_rd_addr,
    input  logic                  wb_reg_we,
    output logic [FWD_W-1:0]      forward_1,
    output logic [FWD_W-1:0]      forward_2,
    output logic                  stall_pc,
    output logic                  stall_if_id,
    output logic                  stall_id_ex,
    output logic                  flush_if_id,
    output logic                  flush_id_ex,
    output logic                  flush_ex_m,
    output logic                  md_abort,
    output logic                  md_timeout,
    output logic [31:0]           stall_cycles,
    output logic [31:0]           flush_count
);

    localparam int unsigned CNT_W = $clog2(MD_MAX_CYCLES + 1);

    localparam logic [0:0] RUN     = 1'b0;
    localparam logic [0:0] MD_BUSY = 1'b1;

    localparam logic [FWD_W-1:0] FWD_NONE = FWD_W'(0);
    localparam logic [FWD_W-1:0] FWD_MEM  = FWD_W'(2);
    localparam logic [FWD_W-1:0] FWD_WB   = FWD_W'(1);

    localparam logic [REG_ADDR_W-1:0] X0 = REG_ADDR_W'(0);

    logic [0:0]       state;
    logic [0:0]       state_nxt;
    logic [CNT_W-1:0] md_cnt;
    logic [CNT_W-1:0] md_cnt_nxt;
    logic             timeout_hit;
    logic             ld_use;
    logic             m_fwd_ok;
    logic             wb_fwd_ok;

    // x0 is hardwired zero, so a write to it never needs forwarding
    assign m_fwd_ok  = m_reg_we && (m_rd_addr != X0);
    assign wb_fwd_ok = wb_reg_we && (wb_rd_addr != X0);

    // Operand forwarding; MEM holds the younger result so it wins over WB
    always_comb begin
        forward_1 = FWD_NONE;
        forward_2 = FWD_NONE;
        if (!rst) begin
            if (m_fwd_ok && (m_rd_addr == ex_rs1_addr)) begin
                forward_1 = FWD_MEM;
            end else if (wb_fwd_ok && (wb_rd_addr == ex_rs1_addr)) begin
                forward_1 = FWD_WB;
            end

            if (m_fwd_ok && (m_rd_addr == ex_rs2_addr)) begin
                forward_2 = FWD_MEM;
            end else if (wb_fwd_ok && (wb_rd_addr == ex_rs2_addr)) begin
                forward_2 = FWD_WB;
            end
        end
    end

    // Load in EX whose destination is read by the instruction in ID
    assign ld_use = ex_mem_rd && ex_reg_we && (ex_rd_addr != X0) &&
                    ((id_rs1_used && (id_rs1_addr == ex_rd_addr)) ||
                     (id_rs2_used && (id_rs2_addr == ex_rd_addr)));

    // State, busy counter and sticky timeout flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            md_cnt     <= CNT_W'(0);
            md_timeout <= 1'b0;
        end else begin
            state  <= state_nxt;
            md_cnt <= md_cnt_nxt;
            if (timeout_hit) begin
                md_timeout <= 1'b1;
            end
        end
    end

    // Next state and combinational stall/flush controls
    always_comb begin
        state_nxt   = state;
        md_cnt_nxt  = md_cnt;
        timeout_hit = 1'b0;
        stall_pc    = 1'b0;
        stall_if_id = 1'b0;
        stall_id_ex = 1'b0;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;
        flush_ex_m  = 1'b0;
        md_abort    = 1'b0;

        if (!rst) begin
            case (state)
                RUN: begin
                    md_cnt_nxt = CNT_W'(0);
                    if (ex_md_start) begin
                        stall_pc    = 1'b1;
                        stall_if_id = 1'b1;
                        stall_id_ex = 1'b1;
                        flush_ex_m  = 1'b1;
                        state_nxt   = MD_BUSY;
                        md_cnt_nxt  = CNT_W'(1);
                    end else if (branch_taken_ex) begin
                        flush_if_id = 1'b1;
                        flush_id_ex = 1'b1;
                    end else if (ld_use) begin
                        stall_pc    = 1'b1;
                        stall_if_id = 1'b1;
                        flush_id_ex = 1'b1;
                    end
                end

                MD_BUSY: begin
                    if (md_done) begin
                        state_nxt  = RUN;
                        md_cnt_nxt = CNT_W'(0);
                    end else if (md_cnt == CNT_W'(MD_MAX_CYCLES)) begin
                        md_abort    = 1'b1;
                        timeout_hit = 1'b1;
                        state_nxt   = RUN;
                        md_cnt_nxt  = CNT_W'(0);
                    end else begin
                        stall_pc    = 1'b1;
                        stall_if_id = 1'b1;
                        stall_id_ex = 1'b1;
                        flush_ex_m  = 1'b1;
                        md_cnt_nxt  = md_cnt + CNT_W'(1);
                    end
                end

                default: begin
                    state_nxt  = RUN;
                    md_cnt_nxt = CNT_W'(0);
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    // Saturating performance counters
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            if (stall_pc && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (flush_if_id && (flush_cnt_q != 32'hFFFF_FFFF)) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cycles = stall_cnt_q;
    assign flush_count  = flush_cnt_q;
`else
    assign stall_cycles = 32'd0;
    assign flush_count  = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios with literal expectations plus randomized traffic vs a behavioural model.
module tb_hazard_ctrl;

    localparam int TB_MAX = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs1_addr, id_rs2_addr, ex_rs1_addr, ex_rs2_addr, ex_rd_addr;
    logic [4:0] m_rd_addr, wb_rd_addr;
    logic       id_rs1_used, id_rs2_used, ex_reg_we, ex_mem_rd, ex_md_start;
    logic       md_done, branch_taken_ex, m_reg_we, wb_reg_we;
    logic [1:0] forward_1, forward_2;
    logic       stall_pc, stall_if_id, stall_id_ex, flush_if_id, flush_id_ex, flush_ex_m;
    logic       md_abort, md_timeout;
    logic [31:0] stall_cycles, flush_count;

    always #5 clk = ~clk;

    hazard_ctrl #(
        .REG_ADDR_W(5), .FWD_W(2), .MD_MAX_CYCLES(TB_MAX)
    ) dut (
        .clk(clk), .rst(rst),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_rs1_addr(ex_rs1_addr), .ex_rs2_addr(ex_rs2_addr), .ex_rd_addr(ex_rd_addr),
        .ex_reg_we(ex_reg_we), .ex_mem_rd(ex_mem_rd), .ex_md_start(ex_md_start),
        .md_done(md_done), .branch_taken_ex(branch_taken_ex),
        .m_rd_addr(m_rd_addr), .m_reg_we(m_reg_we),
        .wb_rd_addr(wb_rd_addr), .wb_reg_we(wb_reg_we),
        .forward_1(forward_1), .forward_2(forward_2),
        .stall_pc(stall_pc), .stall_if_id(stall_if_id), .stall_id_ex(stall_id_ex),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .flush_ex_m(flush_ex_m),
        .md_abort(md_abort), .md_timeout(md_timeout),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    // Behavioural model state: is a mul/div in flight, and for how many cycles
    bit          m_busy = 1'b0;
    int          m_cyc = 0;
    bit          m_timeout = 1'b0;
    logic [31:0] m_stall_cnt = 32'd0;
    logic [31:0] m_flush_cnt = 32'd0;

    logic [1:0]  e_f1, e_f2;
    logic [7:0]  e_ctrl;
    logic        e_ld_use;

    function automatic logic [1:0] fwd_of(input logic [4:0] rs);
        if (m_reg_we && m_rd_addr != 5'd0 && m_rd_addr == rs) return 2'b10;
        if (wb_reg_we && wb_rd_addr != 5'd0 && wb_rd_addr == rs) return 2'b01;
        return 2'b00;
    endfunction

    // ctrl vector: {stall_pc, stall_if_id, stall_id_ex, flush_if_id, flush_id_ex, flush_ex_m, md_abort, md_timeout}
    always_comb begin
        e_f1 = 2'b00;
        e_f2 = 2'b00;
        e_ctrl = {7'b0, m_timeout};
        e_ld_use = ex_mem_rd && ex_reg_we && ex_rd_addr != 5'd0 &&
                   ((id_rs1_used && id_rs1_addr == ex_rd_addr) || (id_rs2_used && id_rs2_addr == ex_rd_addr));
        if (!rst) begin
            e_f1 = fwd_of(ex_rs1_addr);
            e_f2 = fwd_of(ex_rs2_addr);
            if (!m_busy) begin
                if (ex_md_start)          e_ctrl[7:1] = 7'b1110010;
                else if (branch_taken_ex) e_ctrl[7:1] = 7'b0001100;
                else if (e_ld_use)        e_ctrl[7:1] = 7'b1100100;
            end else begin
                if (md_done)              e_ctrl[7:1] = 7'b0000000;
                else if (m_cyc == TB_MAX) e_ctrl[7:1] = 7'b0000001;
                else                      e_ctrl[7:1] = 7'b1110010;
            end
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_cyc <= 0;
            m_timeout <= 1'b0;
            m_stall_cnt <= 32'd0;
            m_flush_cnt <= 32'd0;
        end else begin
            if (!m_busy) begin
                if (ex_md_start) begin
                    m_busy <= 1'b1;
                    m_cyc <= 1;
                end
            end else if (md_done) begin
                m_busy <= 1'b0;
            end else if (m_cyc == TB_MAX) begin
                m_busy <= 1'b0;
                m_timeout <= 1'b1;
            end else begin
                m_cyc <= m_cyc + 1;
            end
            if (e_ctrl[7] && m_stall_cnt != 32'hFFFF_FFFF) m_stall_cnt <= m_stall_cnt + 32'd1;
            if (e_ctrl[4] && m_flush_cnt != 32'hFFFF_FFFF) m_flush_cnt <= m_flush_cnt + 32'd1;
        end
    end

    int         checks = 0;
    int         failures = 0;
    bit         chk_en = 1'b0;
    bit         lit_en = 1'b0;
    logic [1:0] lit_f1, lit_f2;
    logic [7:0] lit_ctrl;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%h expected=%h", name, $time, act, exp);
        end
    endtask

    // Single compare process: DUT vs model every cycle, model/DUT vs literals when pinned
    always @(negedge clk) begin
        if (chk_en) begin
            logic [7:0]  d_ctrl;
            logic [31:0] e_sc, e_fc;
            d_ctrl = {stall_pc, stall_if_id, stall_id_ex, flush_if_id, flush_id_ex, flush_ex_m, md_abort, md_timeout};
`ifdef HAZARD_PERF_CNT_EN
            e_sc = m_stall_cnt;
            e_fc = m_flush_cnt;
`else
            e_sc = 32'd0;
            e_fc = 32'd0;
`endif
            check("forward_1", {30'd0, forward_1}, {30'd0, e_f1});
            check("forward_2", {30'd0, forward_2}, {30'd0, e_f2});
            check("ctrl", {24'd0, d_ctrl}, {24'd0, e_ctrl});
            check("stall_cycles", stall_cycles, e_sc);
            check("flush_count", flush_count, e_fc);
            if (lit_en) begin
                check("lit_model", {20'd0, e_f1, e_f2, e_ctrl}, {20'd0, lit_f1, lit_f2, lit_ctrl});
                check("lit_dut", {20'd0, forward_1, forward_2, d_ctrl}, {20'd0, lit_f1, lit_f2, lit_ctrl});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        lit_en = 1'b0;
    endtask

    task automatic idle();
        rst = 1'b0;
        {id_rs1_addr, id_rs2_addr, ex_rs1_addr, ex_rs2_addr, ex_rd_addr, m_rd_addr, wb_rd_addr} = '0;
        {id_rs1_used, id_rs2_used, ex_reg_we, ex_mem_rd, ex_md_start} = '0;
        {md_done, branch_taken_ex, m_reg_we, wb_reg_we} = '0;
    endtask

    task automatic lit(input logic [1:0] f1, input logic [1:0] f2, input logic [7:0] c);
        lit_f1 = f1;
        lit_f2 = f2;
        lit_ctrl = c;
        lit_en = 1'b1;
    endtask

    task automatic load_use_x7();
        ex_mem_rd = 1'b1; ex_reg_we = 1'b1; ex_rd_addr = 5'd7;
        id_rs2_addr = 5'd7; id_rs2_used = 1'b1;
    endtask

    localparam logic [7:0] C_MD  = 8'b1110_0100;
    localparam logic [7:0] C_LU  = 8'b1100_1000;
    localparam logic [7:0] C_BR  = 8'b0001_1000;
    localparam logic [7:0] C_AB  = 8'b0000_0010;
    localparam logic [7:0] C_TO  = 8'b0000_0001;

    initial begin
        idle();
        rst = 1'b1;
        tick();
        chk_en = 1'b1;
        // Reset holds forwarding and controls at zero even with matching inputs
        idle(); rst = 1'b1; m_reg_we = 1'b1; m_rd_addr = 5'd5; ex_rs1_addr = 5'd5; ex_md_start = 1'b1;
        lit(2'b00, 2'b00, 8'h00);
        tick();
        idle(); m_reg_we = 1'b1; m_rd_addr = 5'd5; wb_reg_we = 1'b1; wb_rd_addr = 5'd5; ex_rs1_addr = 5'd5;
        lit(2'b10, 2'b00, 8'h00);
        tick();
        m_reg_we = 1'b0;
        lit(2'b01, 2'b00, 8'h00);
        tick();
        idle(); load_use_x7();
        lit(2'b00, 2'b00, C_LU);
        tick();
        idle(); m_reg_we = 1'b1; m_rd_addr = 5'd7; ex_rs2_addr = 5'd7;
        lit(2'b00, 2'b10, 8'h00);
        tick();
        idle(); load_use_x7(); branch_taken_ex = 1'b1;
        lit(2'b00, 2'b00, C_BR);
        tick();
        // mul/div completing on its 4th busy-phase cycle
        idle(); ex_md_start = 1'b1;
        lit(2'b00, 2'b00, C_MD);
        for (int i = 1; i <= 3; i++) begin
            tick(); idle(); lit(2'b00, 2'b00, C_MD);
        end
        tick(); idle(); md_done = 1'b1; lit(2'b00, 2'b00, 8'h00);
        tick(); idle(); lit(2'b00, 2'b00, 8'h00);
        // mul/div that never finishes
        tick(); idle(); ex_md_start = 1'b1; lit(2'b00, 2'b00, C_MD);
        for (int i = 1; i < TB_MAX; i++) begin
            tick(); idle(); lit(2'b00, 2'b00, C_MD);
        end
        tick(); idle(); lit(2'b00, 2'b00, C_AB);
        for (int i = 0; i < 3; i++) begin
            tick(); idle(); lit(2'b00, 2'b00, C_TO);
        end
        // reset in the third busy cycle
        tick(); idle(); ex_md_start = 1'b1; lit(2'b00, 2'b00, C_MD | C_TO);
        tick(); idle(); lit(2'b00, 2'b00, C_MD | C_TO);
        tick(); idle(); lit(2'b00, 2'b00, C_MD | C_TO);
        tick(); idle(); rst = 1'b1; lit(2'b00, 2'b00, C_TO);
        tick(); idle(); lit(2'b00, 2'b00, 8'h00);
        // randomized traffic over a small register range to provoke matches
        for (int n = 0; n < 3000; n++) begin
            tick();
            rst             = ($urandom_range(0, 199) == 0);
            id_rs1_addr     = 5'($urandom_range(0, 3));
            id_rs2_addr     = 5'($urandom_range(0, 3));
            ex_rs1_addr     = 5'($urandom_range(0, 3));
            ex_rs2_addr     = 5'($urandom_range(0, 3));
            ex_rd_addr      = 5'($urandom_range(0, 3));
            m_rd_addr       = 5'($urandom_range(0, 3));
            wb_rd_addr      = 5'($urandom_range(0, 3));
            id_rs1_used     = 1'($urandom_range(0, 1));
            id_rs2_used     = 1'($urandom_range(0, 1));
            ex_reg_we       = 1'($urandom_range(0, 1));
            ex_mem_rd       = 1'($urandom_range(0, 1));
            m_reg_we        = 1'($urandom_range(0, 1));
            wb_reg_we       = 1'($urandom_range(0, 1));
            branch_taken_ex = ($urandom_range(0, 5) == 0);
            ex_md_start     = !m_busy && ($urandom_range(0, 9) == 0);
            md_done         = ($urandom_range(0, 8) == 0);
        end
        tick();
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
